// File: rtl/mips_pipe_pkg.sv
// Shared constants and types for the 5-stage MIPS pipeline.
package mips_pipe_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned RA_W_DEFAULT   = 5;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Main-control decoder outputs carried down the pipe.
  typedef struct packed {
    logic       regdst;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary signals: ID-side inputs, EX-side registered copies and stall outputs.
interface id_ex_stage_reg_if #(
  parameter int unsigned DATA_W = mips_pipe_pkg::DATA_W_DEFAULT,
  parameter int unsigned RA_W   = mips_pipe_pkg::RA_W_DEFAULT,
  parameter int unsigned CNT_W  = 16
);
  logic              flush;
  logic              id_valid;
  logic              id_regdst, id_branch, id_memread, id_memtoreg;
  logic              id_memwrite, id_alusrc, id_regwrite;
  logic [1:0]        id_aluop;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm, id_pc4;
  logic [RA_W-1:0]   id_rs, id_rt, id_rd;

  logic              ex_valid;
  logic              ex_regdst, ex_branch, ex_memread, ex_memtoreg;
  logic              ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0]        ex_aluop;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [RA_W-1:0]   ex_rs, ex_rt, ex_rd;

  logic              pc_write;
  logic              ifid_write;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output flush, id_valid, id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite,
           id_alusrc, id_regwrite, id_aluop, id_rd1, id_rd2, id_imm, id_pc4, id_rs, id_rt, id_rd,
    input  ex_valid, ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc,
           ex_regwrite, ex_aluop, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
           pc_write, ifid_write, bubble_cnt
  );

  modport slave (
    input  flush, id_valid, id_regdst, id_branch, id_memread, id_memtoreg, id_memwrite,
           id_alusrc, id_regwrite, id_aluop, id_rd1, id_rd2, id_imm, id_pc4, id_rs, id_rt, id_rd,
    output ex_valid, ex_regdst, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc,
           ex_regwrite, ex_aluop, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
           pc_write, ifid_write, bubble_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection; stall is masked when the ID instruction is flushed.
module load_use_detect #(
  parameter int unsigned RA_W = 5
) (
  input  logic            ex_valid,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            flush,
  output logic            haz,
  output logic            stall
);
  // $zero is never a real load destination.
  assign haz = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
               ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign stall = haz & ~flush;
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: bubble insertion on flush or load-use, saturating bubble counter.
module id_ex_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned RA_W   = RA_W_DEFAULT,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_stage_reg_if.slave bus
);
  ctrl_t             id_ctrl, ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q, pc4_q;
  logic [RA_W-1:0]   rs_q, rt_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              haz, stall, bubble;

  assign id_ctrl = {bus.id_regdst, bus.id_branch, bus.id_memread, bus.id_memtoreg,
                    bus.id_memwrite, bus.id_alusrc, bus.id_regwrite, bus.id_aluop};

  load_use_detect #(
    .RA_W(RA_W)
  ) u_load_use_detect (
    .ex_valid  (valid_q),
    .ex_memread(ctrl_q.memread),
    .ex_rt     (rt_q),
    .id_valid  (bus.id_valid),
    .id_rs     (bus.id_rs),
    .id_rt     (bus.id_rt),
    .flush     (bus.flush),
    .haz       (haz),
    .stall     (stall)
  );

  // Flush and hazard together still make a single bubble.
  assign bubble = bus.flush | haz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else if (bubble) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= id_ctrl;
      valid_q <= bus.id_valid;
    end
  end

  // Datapath fields are don't-care under a bubble, so they simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rd2_q <= '0;
      imm_q <= '0;
      pc4_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
    end else if (!bubble) begin
      rd1_q <= bus.id_rd1;
      rd2_q <= bus.id_rd2;
      imm_q <= bus.id_imm;
      pc4_q <= bus.id_pc4;
      rs_q  <= bus.id_rs;
      rt_q  <= bus.id_rt;
      rd_q  <= bus.id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_regdst   = ctrl_q.regdst;
  assign bus.ex_branch   = ctrl_q.branch;
  assign bus.ex_memread  = ctrl_q.memread;
  assign bus.ex_memtoreg = ctrl_q.memtoreg;
  assign bus.ex_memwrite = ctrl_q.memwrite;
  assign bus.ex_alusrc   = ctrl_q.alusrc;
  assign bus.ex_regwrite = ctrl_q.regwrite;
  assign bus.ex_aluop    = ctrl_q.aluop;
  assign bus.ex_rd1      = rd1_q;
  assign bus.ex_rd2      = rd2_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_pc4      = pc4_q;
  assign bus.ex_rs       = rs_q;
  assign bus.ex_rt       = rt_q;
  assign bus.ex_rd       = rd_q;
  assign bus.pc_write    = ~stall;
  assign bus.ifid_write  = ~stall;
  assign bus.bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed vector bench for id_ex_stage_reg: stall, bubble, flush, reset and saturation.
module tb_id_ex_stage_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DATA_W(32), .RA_W(5), .CNT_W(16)) bus ();
  id_ex_stage_reg_if #(.DATA_W(32), .RA_W(5), .CNT_W(4))  bus4 ();

  id_ex_stage_reg #(.DATA_W(32), .RA_W(5), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  id_ex_stage_reg #(.DATA_W(32), .RA_W(5), .CNT_W(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4.slave)
  );

  // {regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop[1:0]}
  localparam logic [8:0] C_R   = 9'b1_0_0_0_0_0_1_10;
  localparam logic [8:0] C_LW  = 9'b0_0_1_1_0_1_1_00;
  localparam logic [8:0] C_SW  = 9'b0_0_0_0_1_1_0_00;
  localparam logic [8:0] C_BEQ = 9'b0_1_0_0_0_0_0_01;
  localparam logic [8:0] C_0   = 9'b0;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [8:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1;
    logic        exp_pcw;
    logic        exp_valid;
    logic [8:0]  exp_ctrl;
    logic [15:0] exp_cnt;
    logic        chk_dp;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(logic fl, logic va, logic [8:0] c, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] rd, logic [31:0] rd1, logic pcw, logic ev,
                              logic [8:0] ec, logic [15:0] cnt, logic dp);
    vec_t v;
    v.flush = fl; v.valid = va; v.ctrl = c; v.rs = rs; v.rt = rt; v.rd = rd; v.rd1 = rd1;
    v.exp_pcw = pcw; v.exp_valid = ev; v.exp_ctrl = ec; v.exp_cnt = cnt; v.chk_dp = dp;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic fl, logic va, logic [8:0] c, logic [4:0] rs, logic [4:0] rt,
                       logic [4:0] rd, logic [31:0] rd1);
    bus.flush = fl;
    bus.id_valid = va;
    {bus.id_regdst, bus.id_branch, bus.id_memread, bus.id_memtoreg, bus.id_memwrite,
     bus.id_alusrc, bus.id_regwrite, bus.id_aluop} = c;
    bus.id_rs = rs;
    bus.id_rt = rt;
    bus.id_rd = rd;
    bus.id_rd1 = rd1;
    bus.id_rd2 = rd1 ^ 32'hFFFF_0000;
    bus.id_imm = ~rd1;
    bus.id_pc4 = rd1 + 32'd4;
  endtask

  function automatic logic [8:0] ex_ctrl();
    return {bus.ex_regdst, bus.ex_branch, bus.ex_memread, bus.ex_memtoreg, bus.ex_memwrite,
            bus.ex_alusrc, bus.ex_regwrite, bus.ex_aluop};
  endfunction

  initial begin
    bus4.flush = 1'b0; bus4.id_valid = 1'b0;
    {bus4.id_regdst, bus4.id_branch, bus4.id_memread, bus4.id_memtoreg, bus4.id_memwrite,
     bus4.id_alusrc, bus4.id_regwrite, bus4.id_aluop} = '0;
    bus4.id_rd1 = '0; bus4.id_rd2 = '0; bus4.id_imm = '0; bus4.id_pc4 = '0;
    bus4.id_rs = '0; bus4.id_rt = '0; bus4.id_rd = '0;

    // Reset with random ID-side inputs
    drive(1'b0, 1'b1, 9'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(bus.ex_valid), 0);
    chk("rst_ex_ctrl", 32'(ex_ctrl()), 0);
    chk("rst_ex_rd1", bus.ex_rd1, 0);
    chk("rst_ex_rt", 32'(bus.ex_rt), 0);
    chk("rst_cnt", 32'(bus.bubble_cnt), 0);
    chk("rst_pc_write", 32'(bus.pc_write), 1);
    chk("rst_ifid_write", 32'(bus.ifid_write), 1);
    rst_n = 1'b1;

    //                fl va ctrl  rs  rt  rd  rd1           pcw ev exp_ctrl cnt dp
    vecs.push_back(mk(0, 1, C_R,   1,  2,  8, 32'h1234,     1,  1, C_R,   0, 1)); // R pass
    vecs.push_back(mk(0, 1, C_LW,  3,  9,  0, 32'h1000,     1,  1, C_LW,  0, 1)); // lw $9
    vecs.push_back(mk(0, 1, C_R,   9,  4, 10, 32'h2222,     0,  0, C_0,   1, 0)); // use rs
    vecs.push_back(mk(0, 1, C_R,   9,  4, 10, 32'h2222,     1,  1, C_R,   1, 1)); // replay
    vecs.push_back(mk(0, 1, C_LW,  5,  0,  0, 32'h3000,     1,  1, C_LW,  1, 1)); // lw $0
    vecs.push_back(mk(0, 1, C_R,   0,  0, 11, 32'h3333,     1,  1, C_R,   1, 1)); // no haz
    vecs.push_back(mk(0, 1, C_LW,  1, 12,  0, 32'h4000,     1,  1, C_LW,  1, 1)); // lw $12
    vecs.push_back(mk(1, 1, C_SW,  2, 12,  0, 32'h4444,     1,  0, C_0,   2, 0)); // flush+haz
    vecs.push_back(mk(0, 1, C_BEQ, 12, 3,  0, 32'h5555,     1,  1, C_BEQ, 2, 1));
    vecs.push_back(mk(1, 1, C_R,   1,  2,  3, 32'h6666,     1,  0, C_0,   3, 0)); // flush
    vecs.push_back(mk(0, 0, C_LW,  1,  7,  0, 32'h7000,     1,  0, C_LW,  3, 1)); // invalid lw
    vecs.push_back(mk(0, 1, C_R,   7,  1,  2, 32'h7777,     1,  1, C_R,   3, 1)); // no haz
    vecs.push_back(mk(0, 1, C_LW,  2,  6,  0, 32'h8000,     1,  1, C_LW,  3, 1)); // lw $6
    vecs.push_back(mk(0, 1, C_R,   1,  6, 13, 32'h8888,     0,  0, C_0,   4, 0)); // use rt
    vecs.push_back(mk(0, 1, C_R,   1,  6, 13, 32'h8888,     1,  1, C_R,   4, 1));
    vecs.push_back(mk(0, 1, C_LW,  2,  6,  0, 32'h9000,     1,  1, C_LW,  4, 1));
    vecs.push_back(mk(0, 0, C_R,   6,  6, 14, 32'h9999,     1,  0, C_R,   4, 1)); // id invalid

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.flush, v.valid, v.ctrl, v.rs, v.rt, v.rd, v.rd1);
      #1;
      chk($sformatf("v%0d_pc_write", i), 32'(bus.pc_write), 32'(v.exp_pcw));
      chk($sformatf("v%0d_ifid_write", i), 32'(bus.ifid_write), 32'(v.exp_pcw));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ex_valid", i), 32'(bus.ex_valid), 32'(v.exp_valid));
      chk($sformatf("v%0d_ex_ctrl", i), 32'(ex_ctrl()), 32'(v.exp_ctrl));
      chk($sformatf("v%0d_cnt", i), 32'(bus.bubble_cnt), 32'(v.exp_cnt));
      if (v.chk_dp) begin
        chk($sformatf("v%0d_ex_rs", i), 32'(bus.ex_rs), 32'(v.rs));
        chk($sformatf("v%0d_ex_rt", i), 32'(bus.ex_rt), 32'(v.rt));
        chk($sformatf("v%0d_ex_rd", i), 32'(bus.ex_rd), 32'(v.rd));
        chk($sformatf("v%0d_ex_rd1", i), bus.ex_rd1, v.rd1);
        chk($sformatf("v%0d_ex_rd2", i), bus.ex_rd2, v.rd1 ^ 32'hFFFF_0000);
        chk($sformatf("v%0d_ex_imm", i), bus.ex_imm, ~v.rd1);
        chk($sformatf("v%0d_ex_pc4", i), bus.ex_pc4, v.rd1 + 32'd4);
      end
    end

    // Reset asserted while a load-use stall is active
    drive(0, 1, C_LW, 3, 9, 0, 32'hA000);
    @(posedge clk);
    #1;
    drive(0, 1, C_R, 9, 4, 10, 32'hAAAA);
    #1;
    chk("midrst_stall_pc_write", 32'(bus.pc_write), 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ex_valid", 32'(bus.ex_valid), 0);
    chk("midrst_ex_memread", 32'(bus.ex_memread), 0);
    chk("midrst_cnt", 32'(bus.bubble_cnt), 0);
    chk("midrst_pc_write", 32'(bus.pc_write), 1);
    rst_n = 1'b1;
    #1;
    chk("postrst_pc_write", 32'(bus.pc_write), 1);
    @(posedge clk);
    #1;
    chk("postrst_ex_valid", 32'(bus.ex_valid), 1);
    chk("postrst_ex_rs", 32'(bus.ex_rs), 9);
    chk("postrst_ex_rd1", bus.ex_rd1, 32'hAAAA);
    chk("postrst_cnt", 32'(bus.bubble_cnt), 0);

    // Saturation on the 4-bit counter instance
    bus4.flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_cnt3", 32'(bus4.bubble_cnt), 3);
    repeat (17) @(posedge clk);
    #1;
    chk("sat_cnt20", 32'(bus4.bubble_cnt), 32'hF);
    chk("sat_ex_valid", 32'(bus4.ex_valid), 0);
    bus4.flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
